nibble_fifo_serial_tx: RTL
==========================

# nibble_fifo_serial_tx

Downstream drain stage for the nibble-packing byte FIFO. It pulls one 8-bit byte at a time from the FIFO's read side using the FIFO's valid/enable handshake. Each byte is then shifted out on a single-wire asynchronous serial line: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits. It is the last stage before the off-block serial pin.

## Interface

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range ≥ 1.
- PARITY_EN, default 0: 1 inserts an even-parity bit after data bit 7.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_valid  in  1  FIFO has a byte available; connects to the FIFO's output_valid.
- fifo_data  in  8  FIFO read data; connects to Data_Out; valid the cycle after the read edge.
- fifo_rd_en  out  1  one-cycle read request; connects to the FIFO's output_enable.
- tx  out  1  serial line; idles high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame's last stop bit completes.
- bytes_sent  out  8  count of completed frames; wraps 255→0.

## Operation

- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, bytes_sent=0, state=IDLE, all counters 0.
- All outputs are registered.

State machine:
- IDLE: if fifo_valid=1, go to REQ.
- REQ: fifo_rd_en=1 for exactly this cycle.
  - If fifo_valid=1 at the end of REQ, go to LOAD.
  - Otherwise abort to IDLE: no frame, no count.
- LOAD: at the edge ending LOAD, capture fifo_data into an 8-bit shift register and compute parity = XOR of the 8 bits. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift register bit 0 for CLKS_PER_BIT cycles per bit; shift right after each bit. Bit index 0..7; after bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the last cycle's edge: frame_done=1 for the following cycle, bytes_sent increments, return to IDLE.

Counters:
- Bit timer counts 0..CLKS_PER_BIT-1; it is wide enough for 2×CLKS_PER_BIT-1 to cover the 2-stop case.
- Bit index is 3 bits.
- bytes_sent is modulo 256.

Boundary conditions:
- Back-to-back bytes: IDLE always lasts at least 1 cycle between frames.
- Only one byte is requested per frame; no read is issued while busy=1.
- fifo_valid is ignored outside IDLE and REQ.
- A rst high on any edge, including mid-frame, forces the reset values on that edge:
  - tx returns high immediately.
  - No frame_done pulse.
  - The partial byte is lost.
- fifo_data is sampled only at the edge ending LOAD and is ignored at all other times.

## Timing

- Let edge E0 sample fifo_valid=1 in IDLE.
  - fifo_rd_en is high between E0 and E1.
  - The FIFO updates Data_Out at E1.
  - The byte is captured at E2.
  - tx falls at E2.
- Frame length F = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, measured from tx falling to the frame_done pulse start.
- With fifo_valid held high, the fifo_rd_en pulse period is F + 3 cycles.
- busy rises at E0 and falls at the same edge frame_done rises.

## Test plan

- Reset: hold rst for 2 cycles with fifo_valid=1 → tx=1, busy=0, fifo_rd_en=0, frame_done=0, bytes_sent=0 throughout; no read issued.
- Single byte 0xA5 (CLKS_PER_BIT=4, no parity, 1 stop) → one fifo_rd_en pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); one frame_done; bytes_sent=1.
- PARITY_EN=1, STOP_BITS=2, byte 0x07 → parity bit 1 after data; tx high for 8 cycles of stop; frame is 48 cycles.
- Back-to-back: fifo_valid held high with bytes 0x01, 0x02, 0x03 → three fifo_rd_en pulses spaced 43 cycles apart; three frames in order; bytes_sent=3.
- Abort: fifo_valid drops during REQ → return to IDLE; tx stays 1; no frame_done; bytes_sent unchanged.
- Reset mid-DATA (bit 3 of 0xFF) → tx=1 and busy=0 after that edge; no frame_done; bytes_sent=0; next byte transmits normally.

Source files
------------

// File: rtl/nibble_fifo_serial_tx.sv
// Drain stage: pulls one byte per frame from the nibble-packing FIFO and
// shifts it out as an async serial frame (start, 8 data LSB first, opt. even parity, stop).
module nibble_fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] bytes_sent
);

    localparam int TW = $clog2(2 * CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            rd_en_q, rd_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      count_q, count_d;
    logic            bit_end, stop_end;

    assign bit_end  = (timer_q == BIT_LAST);
    assign stop_end = (timer_q == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        unique case (state_q)
            S_IDLE: if (fifo_valid) state_d = S_REQ;
            S_REQ:  state_d = fifo_valid ? S_LOAD : S_IDLE;
            S_LOAD: begin
                shreg_d = fifo_data;
                par_d   = ^fifo_data;
                timer_d = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == S_REQ);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && stop_end;
        count_d = count_q + {7'b0, done_d};
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign bytes_sent = count_q;

endmodule
